// File: rtl/cost_deserializer_pkg.sv
// Shared cost definitions: clog2 helper, FSM state type, padding word.
// Imported by the deserializer, its interface and the min tracker.
// No ports; the padding word is sliced to the cost width by each user.
package cost_deserializer_pkg;

  // Ceiling log2. Value 1 gives 0; used to size slot/index fields.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Widest cost word the padding constant can cover.
  localparam int COST_MAX_WIDTH = 64;

  // All-ones is the maximum cost; short vectors are padded with it so
  // padding can never win an argmin against a real word.
  localparam logic [COST_MAX_WIDTH-1:0] COST_PAD_WORD = {COST_MAX_WIDTH{1'b1}};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/cost_deserializer_if.sv
// Stream bundle for cost_deserializer: word input side and packed vector side.
// slave modport = the deserializer; master modport = producer/consumer.
// Optional min outputs exist only with COST_DESERIALIZER_MIN_TRACK_EN.
interface cost_deserializer_if
  import cost_deserializer_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int INPUTS = 8
);
  localparam int INDEX_BITS = clog2(INPUTS);

  logic                      s_valid;
  logic                      s_ready;
  logic [WIDTH-1:0]          s_data;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [INPUTS*WIDTH-1:0]   m_data;
  logic                      m_error;
`ifdef COST_DESERIALIZER_MIN_TRACK_EN
  logic [WIDTH-1:0]          m_min_value;
  logic [INDEX_BITS-1:0]     m_min_index;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_error, m_min_value, m_min_index
  );
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_error, m_min_value, m_min_index
  );
`else
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_error
  );
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_error
  );
`endif

endinterface

// File: rtl/cost_min_tracker.sv
// Running minimum / argmin over the words of the vector being assembled.
// Ports: clk/rst; word_vld/word_dat/word_idx = accepted word and its slot;
// cand_min/cand_idx = minimum including the current word (combinational).
module cost_min_tracker #(
  parameter int WIDTH      = 2,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_vld,
  input  logic [WIDTH-1:0]      word_dat,
  input  logic [INDEX_BITS-1:0] word_idx,
  output logic [WIDTH-1:0]      cand_min,
  output logic [INDEX_BITS-1:0] cand_idx
);

  logic [WIDTH-1:0]      run_min;
  logic [INDEX_BITS-1:0] run_idx;

  // Slot 0 restarts the search. Strict less-than keeps the lowest index
  // on ties, which also means all-ones padding (higher slots, maximum
  // value) can never displace a real word, so it needs no explicit pass.
  always_comb begin
    cand_min = run_min;
    cand_idx = run_idx;
    if (word_idx == '0 || word_dat < run_min) begin
      cand_min = word_dat;
      cand_idx = word_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min <= '0;
      run_idx <= '0;
    end else if (word_vld) begin
      run_min <= cand_min;
      run_idx <= cand_idx;
    end
  end

endmodule

// File: rtl/cost_deserializer.sv
// Packs INPUTS cost words of WIDTH bits into one vector for the argmin tree.
// Ports: clk, rst (sync, active high), bus (slave modport): s_valid/s_ready/
// s_data/s_last in, m_valid/m_ready/m_data/m_error out; word i at [WIDTH*i +: WIDTH].
// Macro COST_DESERIALIZER_MIN_TRACK_EN adds m_min_value/m_min_index via cost_min_tracker.
module cost_deserializer
  import cost_deserializer_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int INPUTS = 8
) (
  input  logic               clk,
  input  logic               rst,
  cost_deserializer_if.slave bus
);

  localparam int INDEX_BITS = clog2(INPUTS);
  localparam logic [INDEX_BITS-1:0] LAST_SLOT = INDEX_BITS'(INPUTS - 1);
  localparam logic [WIDTH-1:0]      PAD_WORD  = COST_PAD_WORD[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > COST_MAX_WIDTH) begin : g_bad_width
    $error("cost_deserializer: WIDTH must be in 1..%0d", COST_MAX_WIDTH);
  end
  if (INPUTS < 2 || (INPUTS & (INPUTS - 1)) != 0) begin : g_bad_inputs
    $error("cost_deserializer: INPUTS must be a power of two >= 2");
  end

  state_t                  state;
  logic                    s_ready_q;
  logic [INDEX_BITS-1:0]   cnt;
  logic [WIDTH-1:0]        slots [INPUTS];
  logic                    hold_err;
  logic [INPUTS*WIDTH-1:0] m_data_q;
  logic                    m_valid_q;
  logic                    m_error_q;

  logic                    accept;
  logic                    at_last_slot;
  logic                    close;
  logic                    close_err;
  logic                    out_free;
  logic                    load_direct;
  logic                    enter_hold;
  logic                    hold_xfer;
  logic [INPUTS*WIDTH-1:0] closed_vec;
  logic [INPUTS*WIDTH-1:0] held_vec;

  // s_ready is only ever high in FILL, so accept implies FILL.
  assign accept       = bus.s_valid && s_ready_q;
  assign at_last_slot = (cnt == LAST_SLOT);
  assign close        = accept && (at_last_slot || bus.s_last);
  // Clean framing only when s_last lands exactly on the final slot.
  assign close_err    = !(at_last_slot && bus.s_last);
  assign out_free     = !m_valid_q || bus.m_ready;
  assign load_direct  = close && out_free;
  assign enter_hold   = close && !out_free;
  assign hold_xfer    = (state == ST_HOLD) && bus.m_ready;

  // Vector as it would look if the current word closes it: earlier slots
  // from the assembly, the live word in slot cnt, all-ones above it.
  always_comb begin
    closed_vec = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (INDEX_BITS'(i) < cnt) begin
        closed_vec[i*WIDTH +: WIDTH] = slots[i];
      end else if (INDEX_BITS'(i) == cnt) begin
        closed_vec[i*WIDTH +: WIDTH] = bus.s_data;
      end else begin
        closed_vec[i*WIDTH +: WIDTH] = PAD_WORD;
      end
    end
  end

  always_comb begin
    held_vec = '0;
    for (int i = 0; i < INPUTS; i++) begin
      held_vec[i*WIDTH +: WIDTH] = slots[i];
    end
  end

  // Assembly slots carry no reset: every slot is written or padded before
  // it can reach the output. On entering HOLD the padded vector is parked
  // here so the output can take it later without recomputing padding.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (enter_hold) begin
        for (int i = 0; i < INPUTS; i++) begin
          slots[i] <= closed_vec[i*WIDTH +: WIDTH];
        end
      end else if (!close) begin
        slots[cnt] <= bus.s_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      s_ready_q <= 1'b1;
      cnt       <= '0;
      hold_err  <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_error_q <= 1'b0;
    end else begin
      // Consumed output drops unless a new vector loads on the same edge.
      if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (close) begin
              cnt <= '0;
              if (out_free) begin
                m_data_q  <= closed_vec;
                m_valid_q <= 1'b1;
                m_error_q <= close_err;
              end else begin
                hold_err  <= close_err;
                state     <= ST_HOLD;
                s_ready_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.m_ready) begin
            m_data_q  <= held_vec;
            m_valid_q <= 1'b1;
            m_error_q <= hold_err;
            state     <= ST_FILL;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_FILL;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_error = m_error_q;

`ifdef COST_DESERIALIZER_MIN_TRACK_EN
  logic [WIDTH-1:0]      cand_min;
  logic [INDEX_BITS-1:0] cand_idx;
  logic [WIDTH-1:0]      hold_min;
  logic [INDEX_BITS-1:0] hold_idx;
  logic [WIDTH-1:0]      m_min_value_q;
  logic [INDEX_BITS-1:0] m_min_index_q;

  cost_min_tracker #(
    .WIDTH      (WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_min_tracker (
    .clk      (clk),
    .rst      (rst),
    .word_vld (accept),
    .word_dat (bus.s_data),
    .word_idx (cnt),
    .cand_min (cand_min),
    .cand_idx (cand_idx)
  );

  // Min/index follow the same load paths as m_data so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_min      <= '0;
      hold_idx      <= '0;
      m_min_value_q <= '0;
      m_min_index_q <= '0;
    end else if (load_direct) begin
      m_min_value_q <= cand_min;
      m_min_index_q <= cand_idx;
    end else if (enter_hold) begin
      hold_min <= cand_min;
      hold_idx <= cand_idx;
    end else if (hold_xfer) begin
      m_min_value_q <= hold_min;
      m_min_index_q <= hold_idx;
    end
  end

  assign bus.m_min_value = m_min_value_q;
  assign bus.m_min_index = m_min_index_q;
`endif

endmodule
